enigma_ctrl: RTL and testbench

- Sequencer for the enigma datapath. Accepts one ASCII character per transaction and applies odometer stepping to three rotor positions.
- Drives a single shared rotor engine through seven stages: forward slots 0,1,2; internal reflector; reverse slots 2,1,0. Returns the ciphertext character over a valid/ready handshake.
- Sits between the keyboard/UART front end and the rotor instance. Owns all rotor position state.

---
 rtl/enigma_ctrl_if.sv | 34 +++
 rtl/enigma_ctrl.sv | 178 +++++++++++++++++
 tb/tb_enigma_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_ctrl_if.sv
// Bundle of handshake, config, rotor-engine and status signals around enigma_ctrl.
// The controller is the slave; the surrounding system (front end plus rotor engine) is the master.
interface enigma_ctrl_if;
  logic        cfg_we;
  logic [1:0]  cfg_slot;
  logic [4:0]  cfg_pos;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_char;
  logic        out_ready;
  logic        rot_start;
  logic [1:0]  rot_sel;
  logic [4:0]  rot_pos;
  logic        rot_dec;
  logic [7:0]  rot_din;
  logic        rot_done;
  logic [7:0]  rot_dout;
  logic [14:0] pos_out;
  logic        err;

  modport slave (
    input  cfg_we, cfg_slot, cfg_pos, in_valid, in_char, out_ready, rot_done, rot_dout,
    output in_ready, out_valid, out_char, rot_start, rot_sel, rot_pos, rot_dec, rot_din,
    output pos_out, err
  );

  modport master (
    output cfg_we, cfg_slot, cfg_pos, in_valid, in_char, out_ready, rot_done, rot_dout,
    input  in_ready, out_valid, out_char, rot_start, rot_sel, rot_pos, rot_dec, rot_din,
    input  pos_out, err
  );
endinterface

// File: rtl/enigma_ctrl.sv
// Enigma sequencer: steps three rotor positions, then drives one shared rotor engine through
// fwd 0,1,2 / reflector / rev 2,1,0. Define ENIGMA_DOUBLE_STEP_EN for the middle-rotor double step.
module enigma_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 8
) (
  input logic          clk,
  input logic          reset,
  enigma_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StStep, StFwd, StRefl, StBwd, StOut, StErr} state_e;

  state_e        state_q;
  logic [1:0]    k_q;
  logic [7:0]    cur_q;
  logic [4:0]    pos0_q, pos1_q, pos2_q;
  logic [CW-1:0] wait_cnt_q;

  logic [4:0]    nxt0, nxt1, nxt2;
  logic          carry1, carry2;
  logic [1:0]    k_nxt;
  logic [4:0]    pos_k_nxt;
  logic [7:0]    refl;
  logic [CW:0]   wait_nxt;
  logic          timed_out;

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= 8'd65) && (c <= 8'd90);
  endfunction

  function automatic logic [4:0] pick(input logic [1:0] s, input logic [4:0] p0,
                                      input logic [4:0] p1, input logic [4:0] p2);
    case (s)
      2'd0:    return p0;
      2'd1:    return p1;
      default: return p2;
    endcase
  endfunction

  always_comb begin
`ifdef ENIGMA_DOUBLE_STEP_EN
    // Middle rotor at its notch drags itself and the slow rotor along.
    carry1 = (pos0_q == 5'd25) || (pos1_q == 5'd25);
    carry2 = (pos1_q == 5'd25);
`else
    carry1 = (pos0_q == 5'd25);
    carry2 = carry1 && (pos1_q == 5'd25);
`endif
    nxt0      = inc26(pos0_q);
    nxt1      = carry1 ? inc26(pos1_q) : pos1_q;
    nxt2      = carry2 ? inc26(pos2_q) : pos2_q;
    k_nxt     = (state_q == StFwd) ? k_q + 2'd1 : k_q - 2'd1;
    pos_k_nxt = pick(k_nxt, pos0_q, pos1_q, pos2_q);
    refl      = 8'd155 - cur_q;
    wait_nxt  = {1'b0, wait_cnt_q} + {{CW{1'b0}}, 1'b1};
    timed_out = (wait_nxt == (CW+1)'(TIMEOUT));
  end

  assign bus.in_ready = (state_q == StIdle) && !bus.cfg_we && !reset;
  assign bus.pos_out  = {pos2_q, pos1_q, pos0_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      k_q           <= 2'd0;
      cur_q         <= 8'd0;
      pos0_q        <= 5'd0;
      pos1_q        <= 5'd0;
      pos2_q        <= 5'd0;
      wait_cnt_q    <= '0;
      bus.rot_start <= 1'b0;
      bus.rot_sel   <= 2'd0;
      bus.rot_pos   <= 5'd0;
      bus.rot_dec   <= 1'b0;
      bus.rot_din   <= 8'd0;
      bus.out_valid <= 1'b0;
      bus.out_char  <= 8'd0;
      bus.err       <= 1'b0;
    end else begin
      bus.rot_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cfg_we) begin
            if (bus.cfg_pos <= 5'd25) begin
              case (bus.cfg_slot)
                2'd0:    pos0_q <= bus.cfg_pos;
                2'd1:    pos1_q <= bus.cfg_pos;
                2'd2:    pos2_q <= bus.cfg_pos;
                default: ;
              endcase
            end
          end else if (bus.in_valid) begin
            cur_q <= bus.in_char;
            if (is_letter(bus.in_char)) begin
              state_q <= StStep;
            end else begin
              state_q       <= StOut;
              bus.out_valid <= 1'b1;
              bus.out_char  <= bus.in_char;
            end
          end
        end
        StStep: begin
          pos0_q        <= nxt0;
          pos1_q        <= nxt1;
          pos2_q        <= nxt2;
          state_q       <= StFwd;
          k_q           <= 2'd0;
          wait_cnt_q    <= '0;
          bus.rot_start <= 1'b1;
          bus.rot_sel   <= 2'd0;
          bus.rot_pos   <= nxt0;
          bus.rot_dec   <= 1'b0;
          bus.rot_din   <= cur_q;
        end
        StFwd, StBwd: begin
          // A done coinciding with the issue pulse cannot belong to this operation.
          if (bus.rot_start) begin
            wait_cnt_q <= wait_nxt[CW-1:0];
          end else if (bus.rot_done) begin
            if (!is_letter(bus.rot_dout)) begin
              state_q <= StErr;
              bus.err <= 1'b1;
            end else if ((state_q == StFwd && k_q != 2'd2) || (state_q == StBwd && k_q != 2'd0)) begin
              cur_q         <= bus.rot_dout;
              k_q           <= k_nxt;
              wait_cnt_q    <= '0;
              bus.rot_start <= 1'b1;
              bus.rot_sel   <= k_nxt;
              bus.rot_pos   <= pos_k_nxt;
              bus.rot_din   <= bus.rot_dout;
            end else if (state_q == StFwd) begin
              cur_q   <= bus.rot_dout;
              state_q <= StRefl;
            end else begin
              cur_q         <= bus.rot_dout;
              state_q       <= StOut;
              bus.out_valid <= 1'b1;
              bus.out_char  <= bus.rot_dout;
            end
          end else if (timed_out) begin
            state_q <= StErr;
            bus.err <= 1'b1;
          end else begin
            wait_cnt_q <= wait_nxt[CW-1:0];
          end
        end
        StRefl: begin
          cur_q         <= refl;
          state_q       <= StBwd;
          k_q           <= 2'd2;
          wait_cnt_q    <= '0;
          bus.rot_start <= 1'b1;
          bus.rot_sel   <= 2'd2;
          bus.rot_pos   <= pos2_q;
          bus.rot_dec   <= 1'b1;
          bus.rot_din   <= refl;
        end
        StOut: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state_q       <= StIdle;
          end
        end
        StErr: begin
          bus.err <= 1'b1;
        end
        default: state_q <= StErr;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_ctrl.sv
// Directed bench for enigma_ctrl with a behavioural identity rotor that answers 2 cycles after start.
module tb_enigma_ctrl;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  enigma_ctrl_if bus ();
  enigma_ctrl #(.TIMEOUT(TIMEOUT), .CW(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int errors  = 0;

  logic       stub_en  = 1'b1;
  logic       stub_bad = 1'b0;
  int         stub_cnt = 0;
  logic [1:0] log_sel[$];
  logic       log_dec[$];
  logic [4:0] log_pos[$];
  logic [7:0] log_din[$];

  // Rotor stub: identity mapping, done pulse 2 cycles after the start cycle.
  always @(posedge clk) begin
    bus.rot_done <= 1'b0;
    if (bus.rot_start) begin
      log_sel.push_back(bus.rot_sel);
      log_dec.push_back(bus.rot_dec);
      log_pos.push_back(bus.rot_pos);
      log_din.push_back(bus.rot_din);
      if (stub_en) stub_cnt <= 1;
    end else if (stub_cnt == 1) begin
      stub_cnt     <= 0;
      bus.rot_done <= 1'b1;
      bus.rot_dout <= stub_bad ? 8'h30 : bus.rot_din;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_sel.delete();
    log_dec.delete();
    log_pos.delete();
    log_din.delete();
  endtask

  task automatic cfg(input logic [1:0] slot, input logic [4:0] pos);
    bus.cfg_we   = 1'b1;
    bus.cfg_slot = slot;
    bus.cfg_pos  = pos;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, output int lat);
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic complete();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h41;
    tick();
    tick();
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    vectors++; if (bus.rot_start !== 1'b0) begin errors++; $display("FAIL reset_rot_start: got %0b want 0", bus.rot_start); end
    vectors++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", bus.err); end
    vectors++; if (bus.pos_out !== 15'd0) begin errors++; $display("FAIL reset_pos: got %0h want 0", bus.pos_out); end
    vectors++; if (bus.out_char !== 8'd0) begin errors++; $display("FAIL reset_out_char: got %0h want 0", bus.out_char); end
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    tick();
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_letter_a();
    int         lat;
    logic [1:0] exp_sel[6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
    logic       exp_dec[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0] exp_pos[6] = '{5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1};
    logic [7:0] exp_din[6] = '{8'h41, 8'h41, 8'h41, 8'h5a, 8'h5a, 8'h5a};
    clear_log();
    send(8'h41, lat);
    vectors++; if (lat !== 20) begin errors++; $display("FAIL a_latency: got %0d want 20", lat); end
    vectors++; if (bus.out_char !== 8'h5a) begin errors++; $display("FAIL a_out_char: got %0h want 5a", bus.out_char); end
    vectors++; if (bus.pos_out !== {5'd0, 5'd0, 5'd1}) begin errors++; $display("FAIL a_pos: got %0h want 1", bus.pos_out); end
    vectors++; if (log_sel.size() !== 6) begin errors++; $display("FAIL a_starts: got %0d want 6", log_sel.size()); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (log_sel[i] !== exp_sel[i] || log_dec[i] !== exp_dec[i] || log_pos[i] !== exp_pos[i] ||
          log_din[i] !== exp_din[i]) begin
        errors++;
        $display("FAIL a_stage%0d: got sel=%0d dec=%0b pos=%0d din=%0h want sel=%0d dec=%0b pos=%0d din=%0h",
                 i, log_sel[i], log_dec[i], log_pos[i], log_din[i], exp_sel[i], exp_dec[i], exp_pos[i],
                 exp_din[i]);
      end
    end
    complete();
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL a_done_valid: got %0b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL a_back_idle: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_carry();
    int lat;
    pulse_reset();
    // Config has priority over a same-cycle input character.
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h35;
    bus.cfg_we   = 1'b1;
    bus.cfg_slot = 2'd0;
    bus.cfg_pos  = 5'd25;
    #1;
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL cfg_blocks_ready: got %0b want 0", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL cfg_priority: got %0b want 0", bus.out_valid); end
    cfg(2'd1, 5'd25);
    cfg(2'd2, 5'd3);
    cfg(2'd3, 5'd7);
    cfg(2'd0, 5'd26);
    vectors++; if (bus.pos_out !== {5'd3, 5'd25, 5'd25}) begin errors++; $display("FAIL cfg_pos: got %0h want %0h", bus.pos_out, {5'd3, 5'd25, 5'd25}); end
    clear_log();
    send(8'h43, lat);
    vectors++; if (lat !== 20) begin errors++; $display("FAIL c_latency: got %0d want 20", lat); end
    vectors++; if (bus.out_char !== 8'h58) begin errors++; $display("FAIL c_out_char: got %0h want 58", bus.out_char); end
    vectors++; if (bus.pos_out !== {5'd4, 5'd0, 5'd0}) begin errors++; $display("FAIL c_pos: got %0h want %0h", bus.pos_out, {5'd4, 5'd0, 5'd0}); end
    vectors++; if (log_pos[2] !== 5'd4) begin errors++; $display("FAIL c_slot2_pos: got %0d want 4", log_pos[2]); end
    complete();
  endtask

  task automatic test_non_letter();
    int         lat;
    logic [7:0] chars[3] = '{8'h35, 8'h40, 8'h5b};
    for (int i = 0; i < 3; i++) begin
      clear_log();
      send(chars[i], lat);
      vectors++; if (lat !== 0) begin errors++; $display("FAIL pass_lat_%0h: got %0d want 0", chars[i], lat); end
      vectors++; if (bus.out_char !== chars[i]) begin errors++; $display("FAIL pass_char: got %0h want %0h", bus.out_char, chars[i]); end
      complete();
      vectors++; if (log_sel.size() !== 0) begin errors++; $display("FAIL pass_starts_%0h: got %0d want 0", chars[i], log_sel.size()); end
      vectors++; if (bus.pos_out !== {5'd4, 5'd0, 5'd0}) begin errors++; $display("FAIL pass_pos_%0h: got %0h want %0h", chars[i], bus.pos_out, {5'd4, 5'd0, 5'd0}); end
    end
    send(8'h5a, lat);
    vectors++; if (bus.out_char !== 8'h41) begin errors++; $display("FAIL z_out_char: got %0h want 41", bus.out_char); end
    vectors++; if (bus.pos_out !== {5'd4, 5'd0, 5'd1}) begin errors++; $display("FAIL z_pos: got %0h want %0h", bus.pos_out, {5'd4, 5'd0, 5'd1}); end
    complete();
  endtask

  task automatic test_backpressure();
    int lat;
    send(8'h42, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_slot = 2'd0;
        bus.cfg_pos  = 5'd7;
      end
      tick();
      bus.cfg_we = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_char !== 8'h59 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: got valid=%0b char=%0h ready=%0b want 1 59 0", i, bus.out_valid,
                 bus.out_char, bus.in_ready);
      end
    end
    vectors++; if (bus.pos_out !== {5'd4, 5'd0, 5'd2}) begin errors++; $display("FAIL busy_cfg_dropped: got %0h want %0h", bus.pos_out, {5'd4, 5'd0, 5'd2}); end
    complete();
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got valid=%0b ready=%0b want 0 1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_double_step();
    int          lat;
    logic [14:0] exp;
`ifdef ENIGMA_DOUBLE_STEP_EN
    exp = {5'd1, 5'd0, 5'd6};
`else
    exp = {5'd0, 5'd25, 5'd6};
`endif
    pulse_reset();
    cfg(2'd0, 5'd5);
    cfg(2'd1, 5'd25);
    cfg(2'd2, 5'd0);
    send(8'h41, lat);
    vectors++; if (bus.pos_out !== exp) begin errors++; $display("FAIL double_step_pos: got %0h want %0h", bus.pos_out, exp); end
    complete();
  endtask

  task automatic test_timeout();
    int n;
    stub_en      = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h41;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.rot_start && n < 10) begin
      tick();
      n++;
    end
    vectors++; if (n !== 1) begin errors++; $display("FAIL to_first_start: got %0d want 1", n); end
    n = 0;
    while (!bus.err && n < 200) begin
      tick();
      n++;
    end
    vectors++; if (n !== 64) begin errors++; $display("FAIL to_cycles: got %0d want 64", n); end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.err !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.rot_start !== 1'b0) begin
        errors++;
        $display("FAIL err_hold_%0d: got err=%0b ready=%0b valid=%0b start=%0b want 1 0 0 0", i, bus.err,
                 bus.in_ready, bus.out_valid, bus.rot_start);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    stub_en      = 1'b1;
    pulse_reset();
    vectors++; if (bus.err !== 1'b0 || bus.pos_out !== 15'd0) begin errors++; $display("FAIL to_reset: got err=%0b pos=%0h want 0 0", bus.err, bus.pos_out); end
  endtask

  task automatic test_range_fault();
    int n;
    stub_bad     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h44;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.err && n < 50) begin
      tick();
      n++;
    end
    vectors++; if (n !== 4) begin errors++; $display("FAIL range_err_cycles: got %0d want 4", n); end
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL range_outputs: got valid=%0b ready=%0b want 0 0", bus.out_valid, bus.in_ready); end
    stub_bad = 1'b0;
    pulse_reset();
  endtask

  task automatic test_mid_reset();
    int lat;
    cfg(2'd0, 5'd3);
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h45;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.rot_start !== 1'b0 || bus.pos_out !== 15'd0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%0b start=%0b pos=%0h ready=%0b want 0 0 0 0", bus.out_valid,
               bus.rot_start, bus.pos_out, bus.in_ready);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_%0d: got valid=%0b err=%0b ready=%0b want 0 0 1", i, bus.out_valid,
                 bus.err, bus.in_ready);
      end
    end
    send(8'h41, lat);
    vectors++; if (bus.out_char !== 8'h5a || bus.pos_out !== {5'd0, 5'd0, 5'd1}) begin errors++; $display("FAIL fresh_after_reset: got char=%0h pos=%0h want 5a 1", bus.out_char, bus.pos_out); end
    complete();
  endtask

  initial begin
    reset        = 1'b1;
    bus.cfg_we   = 1'b0;
    bus.cfg_slot = 2'd0;
    bus.cfg_pos  = 5'd0;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_letter_a();
    test_carry();
    test_non_letter();
    test_backpressure();
    test_double_step();
    test_timeout();
    test_range_fault();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
